// File: rtl/sysid_checker_if.sv
// sysid_checker_if: Avalon-MM read channel between the checker and the system-ID slave
interface sysid_checker_if;
  logic        address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;
  modport master(output address, read, input waitrequest, readdata, readdatavalid);
  modport slave(input address, read, output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/sysid_checker.sv
// sysid_checker: reads sysid ID and timestamp words after reset or on request and flags mismatches
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h5735_2814,
  parameter bit          CHECK_TS       = 1'b1,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  sysid_checker_if.master avm,
  output logic           busy,
  output logic           done,
  output logic           id_ok,
  output logic           ts_ok,
  output logic           timeout,
  output logic [31:0]    id_value,
  output logic [31:0]    ts_value
);
  typedef enum logic [2:0] {IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, DONE} state_t;
  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);
  state_t      state;
  logic        pending;
  logic [15:0] cnt;
  logic        in_req, in_wait, is_ts, got, expired;
  assign in_req  = state == REQ_ID || state == REQ_TS;
  assign in_wait = state == WAIT_ID || state == WAIT_TS;
  assign is_ts   = state == REQ_TS || state == WAIT_TS;
  // data accepted only while a read is outstanding or being accepted this cycle
  assign got     = avm.readdatavalid && (in_wait || (in_req && !avm.waitrequest));
  assign expired = (in_req || in_wait) && cnt == LIMIT;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pending     <= 1'b1;
      cnt         <= '0;
      avm.read    <= 1'b0;
      avm.address <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      case (state)
        IDLE: if (pending || start) begin
          state       <= REQ_ID;
          pending     <= 1'b0;
          done        <= 1'b0;
          id_ok       <= 1'b0;
          ts_ok       <= 1'b0;
          timeout     <= 1'b0;
          busy        <= 1'b1;
          avm.read    <= 1'b1;
          avm.address <= 1'b0;
          cnt         <= 16'd1;
        end
        DONE: if (start) begin
          state   <= IDLE;
          done    <= 1'b0;
          pending <= 1'b1;
        end
        default:
          if (!(in_req || in_wait)) state <= IDLE;
          else if (got && is_ts) begin
            ts_value <= avm.readdata;
            id_ok    <= id_value == EXPECTED_ID;
            ts_ok    <= CHECK_TS ? avm.readdata == EXPECTED_TS : 1'b1;
            avm.read <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else if (got) begin
            id_value    <= avm.readdata;
            avm.read    <= 1'b1;
            avm.address <= 1'b1;
            cnt         <= 16'd1;
            state       <= REQ_TS;
          end else if (expired) begin
            avm.read <= 1'b0;
            timeout  <= 1'b1;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 16'd1;
            if (in_req && !avm.waitrequest) begin
              avm.read <= 1'b0;
              state    <= is_ts ? WAIT_TS : WAIT_ID;
            end
          end
      endcase
    end
  end
endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: scoreboard bench with a configurable behavioural sysid slave
module tb_sysid_checker;
  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0;
  always #5 clock = ~clock;
  sysid_checker_if bus();
  sysid_checker_if bus2();
  assign bus2.waitrequest   = bus.waitrequest;
  assign bus2.readdata      = bus.readdata;
  assign bus2.readdatavalid = bus.readdatavalid;
  logic busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;
  logic busy2, done2, id_ok2, ts_ok2, timeout2;
  logic [31:0] id_value2, ts_value2;
  sysid_checker #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .avm(bus.master),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout),
    .id_value(id_value), .ts_value(ts_value));
  sysid_checker #(.CHECK_TS(1'b0), .TIMEOUT_CYCLES(8)) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start), .avm(bus2.master),
    .busy(busy2), .done(done2), .id_ok(id_ok2), .ts_ok(ts_ok2), .timeout(timeout2),
    .id_value(id_value2), .ts_value(ts_value2));
  typedef struct {logic id_ok, ts_ok, tmo; logic [31:0] idv, tsv; int cyc;} exp_t;
  exp_t res_q[$];
  logic addr_q[$];
  int checks = 0, fails = 0, cyc, reads = 0;
  int wait_cycles = 0, lat = 0;
  bit never_valid = 0;
  logic [31:0] id_word = 0, ts_word = 0;
  always @(posedge clock or negedge reset_n) cyc <= !reset_n ? 0 : cyc + 1;
  // slave: stalls wait_cycles per read, then returns data lat cycles after the accept cycle
  initial begin
    int stall, pend;
    logic pa;
    stall = 0; pend = 0; pa = 0;
    bus.waitrequest = 0; bus.readdatavalid = 0; bus.readdata = 0;
    forever begin
      @(negedge clock);
      bus.waitrequest = 0;
      bus.readdatavalid = 0;
      if (!reset_n) begin
        stall = 0;
        pend = 0;
      end else if (bus.read) begin
        checks++;
        if (addr_q.size() == 0 || bus.address !== addr_q[0] || bus2.read !== 1'b1 || bus2.address !== bus.address) begin
          fails++;
          $display("FAIL read_address: address %b (dut2 %b), required %b", bus.address, bus2.address, addr_q.size() ? addr_q[0] : 1'bx);
        end
        if (stall < wait_cycles) begin
          bus.waitrequest = 1;
          stall++;
        end else begin
          stall = 0;
          reads++;
          if (addr_q.size()) void'(addr_q.pop_front());
          if (!never_valid && lat == 0) begin
            bus.readdatavalid = 1;
            bus.readdata = bus.address ? ts_word : id_word;
          end else if (!never_valid) begin
            pend = lat;
            pa = bus.address;
          end
        end
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.readdatavalid = 1;
          bus.readdata = pa ? ts_word : id_word;
        end
      end
    end
  end
  task automatic cfg(input int w, input int l, input bit nv, input logic [31:0] iw, input logic [31:0] tw);
    wait_cycles = w; lat = l; never_valid = nv; id_word = iw; ts_word = tw;
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset_n = 0;
    repeat (2) @(negedge clock);
    reset_n = 1;
  endtask
  task automatic wait_done(input int limit, output bit seen);
    seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clock);
      seen = done;
    end
  endtask
  task automatic test_reset();
    @(negedge clock);
    checks++;
    if ({busy, done, id_ok, ts_ok, timeout, id_value, ts_value, bus.read, bus.address} !== '0) begin
      fails++;
      $display("FAIL reset_state: outputs %b_%h_%h, required all zero", {busy, done, id_ok, ts_ok, timeout, bus.read, bus.address}, id_value, ts_value);
    end
  endtask
  task automatic test_run(input string name, input int w, input int l, input logic [31:0] iw, input logic [31:0] tw, input exp_t e_in);
    exp_t e;
    bit seen;
    cfg(w, l, 0, iw, tw);
    addr_q.push_back(0);
    addr_q.push_back(1);
    res_q.push_back(e_in);
    do_reset();
    wait_done(40, seen);
    e = res_q.pop_front();
    checks++;
    if (!seen || cyc !== e.cyc) begin
      fails++;
      $display("FAIL %s done_cycle: done=%b at cycle %0d, required cycle %0d", name, done, cyc, e.cyc);
    end
    checks++;
    if ({id_ok, ts_ok, timeout, id_value, ts_value} !== {e.id_ok, e.ts_ok, e.tmo, e.idv, e.tsv}) begin
      fails++;
      $display("FAIL %s result: ok=%b%b to=%b id=%h ts=%h, required ok=%b%b to=%b id=%h ts=%h", name, id_ok, ts_ok, timeout, id_value, ts_value, e.id_ok, e.ts_ok, e.tmo, e.idv, e.tsv);
    end
    checks++;
    if (addr_q.size() != 0 || busy !== 1'b0 || bus.read !== 1'b0) begin
      fails++;
      $display("FAIL %s idle_after: pending reads %0d busy %b read %b, required 0 0 0", name, addr_q.size(), busy, bus.read);
    end
  endtask
  task automatic test_check_ts_off();
    test_run("ts_off", 0, 0, 32'h0, 32'hDEADBEEF, '{1, 0, 0, 32'h0, 32'hDEADBEEF, 3});
    checks++;
    if ({done2, id_ok2, ts_ok2, timeout2, ts_value2} !== {4'b1110, 32'hDEADBEEF}) begin
      fails++;
      $display("FAIL ts_off dut2: done/id_ok/ts_ok/to=%b%b%b%b ts=%h, required 1110 deadbeef", done2, id_ok2, ts_ok2, timeout2, ts_value2);
    end
  endtask
  task automatic test_restart();
    exp_t e;
    bit seen;
    int n, r0;
    cfg(0, 0, 0, 32'h0, 32'h1234_5678);
    addr_q.push_back(0);
    addr_q.push_back(1);
    res_q.push_back('{1, 0, 0, 32'h0, 32'h1234_5678, 3});
    r0 = reads;
    @(negedge clock);
    start = 1;
    @(negedge clock);
    start = 0;
    n = cyc;
    checks++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL restart done_low: done %b, required 0", done);
    end
    wait_done(20, seen);
    e = res_q.pop_front();
    checks++;
    if (!seen || cyc - n !== e.cyc || reads - r0 !== 2) begin
      fails++;
      $display("FAIL restart timing: done %b after %0d cycles with %0d reads, required %0d cycles and 2 reads", done, cyc - n, reads - r0, e.cyc);
    end
    checks++;
    if ({id_ok, ts_ok, timeout, ts_value} !== {e.id_ok, e.ts_ok, e.tmo, e.tsv}) begin
      fails++;
      $display("FAIL restart result: ok=%b%b to=%b ts=%h, required ok=%b%b to=%b ts=%h", id_ok, ts_ok, timeout, ts_value, e.id_ok, e.ts_ok, e.tmo, e.tsv);
    end
  endtask
  task automatic test_busy_start();
    exp_t e;
    bit seen;
    int n, r0;
    cfg(2, 2, 0, 32'h0, 32'h5735_2814);
    addr_q.push_back(0);
    addr_q.push_back(1);
    res_q.push_back('{1, 1, 0, 32'h0, 32'h5735_2814, 11});
    r0 = reads;
    @(negedge clock);
    start = 1;
    @(negedge clock);
    start = 0;
    n = cyc;
    repeat (3) @(negedge clock);
    start = 1;
    @(negedge clock);
    start = 0;
    wait_done(40, seen);
    e = res_q.pop_front();
    checks++;
    if (!seen || cyc - n !== e.cyc || ts_ok !== e.ts_ok || id_ok !== e.id_ok) begin
      fails++;
      $display("FAIL busy_start done: done %b after %0d cycles ok=%b%b, required %0d cycles ok=%b%b", done, cyc - n, id_ok, ts_ok, e.cyc, e.id_ok, e.ts_ok);
    end
    repeat (6) @(negedge clock);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || reads - r0 !== 2) begin
      fails++;
      $display("FAIL busy_start no_rerun: done %b busy %b reads %0d, required 1 0 2", done, busy, reads - r0);
    end
  endtask
  task automatic test_timeout();
    exp_t e;
    bit seen;
    int r0;
    cfg(1000, 0, 1, 32'h0, 32'h0);
    addr_q.push_back(0);
    res_q.push_back('{0, 0, 1, 32'h0, 32'h0, 9});
    r0 = reads;
    do_reset();
    wait_done(30, seen);
    e = res_q.pop_front();
    checks++;
    if (!seen || cyc !== e.cyc || bus.read !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout timing: done %b at cycle %0d read %b busy %b, required cycle %0d read 0 busy 0", done, cyc, bus.read, busy, e.cyc);
    end
    checks++;
    if ({id_ok, ts_ok, timeout, id_value, ts_value} !== {e.id_ok, e.ts_ok, e.tmo, e.idv, e.tsv} || reads !== r0) begin
      fails++;
      $display("FAIL timeout result: ok=%b%b to=%b id=%h ts=%h accepted %0d, required ok=00 to=1 id=0 ts=0 accepted 0", id_ok, ts_ok, timeout, id_value, ts_value, reads - r0);
    end
    addr_q.delete();
  endtask
  task automatic test_reset_mid();
    bit hit;
    hit = 0;
    cfg(2, 2, 0, 32'h0, 32'h5735_2814);
    addr_q.push_back(0);
    addr_q.push_back(1);
    do_reset();
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clock);
      hit = busy && bus.address && !bus.read;
    end
    #2 reset_n = 0;
    #1;
    checks++;
    if (!hit || {busy, done, id_ok, ts_ok, timeout, id_value, ts_value, bus.read, bus.address} !== '0) begin
      fails++;
      $display("FAIL reset_mid async: reached wait_ts %b outputs %b_%h_%h, required 1 and all zero", hit, {busy, done, timeout, bus.read, bus.address}, id_value, ts_value);
    end
    repeat (2) @(negedge clock);
    addr_q.delete();
    reset_n = 1;
    test_run("reset_mid rerun", 2, 2, 32'h0, 32'h5735_2814, '{1, 1, 0, 32'h0, 32'h5735_2814, 11});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_run("zero_latency", 0, 0, 32'h0, 32'h5735_2814, '{1, 1, 0, 32'h0, 32'h5735_2814, 3});
    test_run("stall", 2, 2, 32'h0, 32'h5735_2814, '{1, 1, 0, 32'h0, 32'h5735_2814, 11});
    test_run("id_mismatch", 0, 0, 32'h1, 32'h5735_2814, '{0, 1, 0, 32'h1, 32'h5735_2814, 3});
    test_check_ts_off();
    test_restart();
    test_busy_start();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
